// File: rtl/lsu_dport.sv
// ============================================================================
// lsu_dport : load/store unit driving a combinational-read, byte-strobed
//             data-memory port. Optional LSU_MISALIGN_EN enables split accesses.
// Rev 1.0
// ============================================================================
`default_nettype none

module lsu_dport #(
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] d_addr,
  output logic [31:0] d_wdata,
  output logic [3:0]  d_wstrb,
  input  logic [31:0] d_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_lo_buf;

  logic        w_accept;
  logic        w_f3_ok;
  logic        w_align_ok;
  logic        w_req_err;
  logic [1:0]  w_off;
  logic [31:0] w_base;
  logic [7:0]  w_m8;
  logic        w_cross;
  logic [31:0] w_hi;
  logic [31:0] w_lo;
  logic [31:0] w_ld_raw;
  logic [31:0] w_ld_ext;
  logic        w_ld_done;

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  assign req_ready = (r_state == IDLE) || (r_state == DONE);
  assign w_accept  = req_valid && req_ready;

  // Legality is judged on the incoming request so errors skip the bus entirely
  assign w_f3_ok = req_we ? (!req_funct3[2] && (req_funct3[1:0] != 2'b11))
                          : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef LSU_MISALIGN_EN
  assign w_align_ok = 1'b1;
`else
  assign w_align_ok = !(((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));
`endif
  assign w_req_err = !w_f3_ok || !w_align_ok;

  assign w_off  = r_addr[1:0];
  assign w_base = {r_addr[31:2], 2'b00};
  assign w_m8   = {4'b0000, size_mask(r_funct3[1:0])} << w_off;
`ifdef LSU_MISALIGN_EN
  assign w_cross = |w_m8[7:4];
`else
  assign w_cross = 1'b0;
`endif

  always_comb begin
    w_next  = r_state;
    d_addr  = 32'h0;
    d_wdata = 32'h0;
    d_wstrb = 4'b0000;
    case (r_state)
      IDLE: if (w_accept) w_next = w_req_err ? DONE : ACC0;
      ACC0: begin
        d_addr  = w_base;
        d_wstrb = r_we ? w_m8[3:0] : 4'b0000;
        d_wdata = r_wdata << {w_off, 3'b000};
        w_next  = w_cross ? ACC1 : DONE;
      end
      ACC1: begin
        d_addr  = w_base + 32'd4;
        d_wstrb = r_we ? w_m8[7:4] : 4'b0000;
        d_wdata = r_wdata >> (6'd32 - {1'b0, w_off, 3'b000});
        w_next  = DONE;
      end
      DONE: begin
        if (w_accept) w_next = w_req_err ? DONE : ACC0;
        else          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // The final access word is taken straight from d_rdata on the edge into DONE
  assign w_hi     = (r_state == ACC1) ? d_rdata  : 32'h0;
  assign w_lo     = (r_state == ACC1) ? r_lo_buf : d_rdata;
  assign w_ld_raw = 32'({w_hi, w_lo} >> {w_off, 3'b000});

  always_comb begin
    case (r_funct3[1:0])
      2'b00:   w_ld_ext = r_funct3[2] ? {24'h0, w_ld_raw[7:0]}
                                      : {{24{w_ld_raw[7]}}, w_ld_raw[7:0]};
      2'b01:   w_ld_ext = r_funct3[2] ? {16'h0, w_ld_raw[15:0]}
                                      : {{16{w_ld_raw[15]}}, w_ld_raw[15:0]};
      default: w_ld_ext = w_ld_raw;
    endcase
  end

  assign w_ld_done = ((r_state == ACC0) && !w_cross) || (r_state == ACC1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_lo_buf <= 32'h0;
    end else begin
      if (w_accept) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
      end
      if (r_state == ACC0) r_lo_buf <= d_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= (w_next == DONE);
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      if (w_accept && w_req_err) begin
        rsp_rdata <= ERR_RDATA;
        rsp_err   <= 1'b1;
      end else if (w_ld_done && !r_we) begin
        rsp_rdata <= w_ld_ext;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_dport.sv
// ============================================================================
// tb_lsu_dport : directed self-checking bench for lsu_dport with a 64-word dmem.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lsu_dport;

  localparam logic [31:0] ERRV = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] d_rdata;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] mem [0:63];
  logic [31:0] bus_addr  [1:5];
  logic [31:0] bus_wdata [1:5];
  logic [3:0]  bus_wstrb [1:5];

  lsu_dport #(.ERR_RDATA(ERRV)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_rdata(d_rdata)
  );

  always #5 clk = ~clk;

  assign d_rdata = mem[d_addr[7:2]];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (d_wstrb[b]) mem[d_addr[7:2]][8*b +: 8] <= d_wdata[8*b +: 8];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request from IDLE, records the bus per cycle, returns latency (0 = timeout)
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat,
                         output logic [31:0] rd, output logic er);
    for (int c = 1; c <= 5; c++) begin
      bus_addr[c] = 32'h0; bus_wdata[c] = 32'h0; bus_wstrb[c] = 4'h0;
    end
    lat = 0; rd = 32'hDEAD_0000; er = 1'b0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      bus_addr[c] = d_addr; bus_wdata[c] = d_wdata; bus_wstrb[c] = d_wstrb;
      if (rsp_valid) begin
        lat = c; rd = rsp_rdata; er = rsp_err;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    repeat (2) tick();
    compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    compared++; if (rsp_rdata !== 32'h0) begin mismatched++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    compared++; if (rsp_err !== 1'b0) begin mismatched++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    compared++; if ({d_addr, d_wdata, d_wstrb} !== 68'h0) begin mismatched++; $display("FAIL reset_bus: got %h/%h/%h want 0", d_addr, d_wdata, d_wstrb); end
    compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sw_lw();
    int lat; logic [31:0] rd; logic er;
    run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rd, er);
    compared++; if (lat !== 2) begin mismatched++; $display("FAIL sw_latency: got %0d want 2", lat); end
    compared++; if (bus_wstrb[1] !== 4'b1111) begin mismatched++; $display("FAIL sw_wstrb: got %b want 1111", bus_wstrb[1]); end
    compared++; if (bus_addr[1] !== 32'h10 || bus_wdata[1] !== 32'hDEADBEEF) begin mismatched++; $display("FAIL sw_bus: got %h/%h want 10/deadbeef", bus_addr[1], bus_wdata[1]); end
    compared++; if (rd !== 32'h0 || er !== 1'b0) begin mismatched++; $display("FAIL sw_rsp: got %h/%b want 0/0", rd, er); end
    compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL sw_pulse: got %b want 0", rsp_valid); end
    run_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er);
    compared++; if (lat !== 2) begin mismatched++; $display("FAIL lw_latency: got %0d want 2", lat); end
    compared++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin mismatched++; $display("FAIL lw_data: got %h/%b want deadbeef/0", rd, er); end
    compared++; if (bus_wstrb[1] !== 4'b0000) begin mismatched++; $display("FAIL lw_wstrb: got %b want 0000", bus_wstrb[1]); end
  endtask

  task automatic test_byte_half();
    int lat; logic [31:0] rd; logic er;
    run_req(1'b1, 3'b010, 32'h10, 32'h11223344, lat, rd, er);
    run_req(1'b1, 3'b000, 32'h13, 32'h000000A5, lat, rd, er);
    compared++; if (bus_wstrb[1] !== 4'b1000 || bus_wdata[1] !== 32'hA5000000) begin mismatched++; $display("FAIL sb_bus: got %b/%h want 1000/a5000000", bus_wstrb[1], bus_wdata[1]); end
    run_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er);
    compared++; if (rd !== 32'hA5223344) begin mismatched++; $display("FAIL sb_word: got %h want a5223344", rd); end
    run_req(1'b0, 3'b000, 32'h13, 32'h0, lat, rd, er);
    compared++; if (rd !== 32'hFFFFFFA5) begin mismatched++; $display("FAIL lb: got %h want ffffffa5", rd); end
    run_req(1'b0, 3'b100, 32'h13, 32'h0, lat, rd, er);
    compared++; if (rd !== 32'h000000A5) begin mismatched++; $display("FAIL lbu: got %h want 000000a5", rd); end
    run_req(1'b1, 3'b001, 32'h22, 32'h00008001, lat, rd, er);
    compared++; if (bus_wstrb[1] !== 4'b1100 || bus_wdata[1] !== 32'h80010000) begin mismatched++; $display("FAIL sh_bus: got %b/%h want 1100/80010000", bus_wstrb[1], bus_wdata[1]); end
    run_req(1'b0, 3'b001, 32'h22, 32'h0, lat, rd, er);
    compared++; if (rd !== 32'hFFFF8001) begin mismatched++; $display("FAIL lh: got %h want ffff8001", rd); end
    run_req(1'b0, 3'b101, 32'h22, 32'h0, lat, rd, er);
    compared++; if (rd !== 32'h00008001) begin mismatched++; $display("FAIL lhu: got %h want 00008001", rd); end
  endtask

  task automatic test_illegal();
    int lat; logic [31:0] rd; logic er;
    run_req(1'b0, 3'b011, 32'h10, 32'h0, lat, rd, er);
    compared++; if (lat !== 1) begin mismatched++; $display("FAIL ill_ld_latency: got %0d want 1", lat); end
    compared++; if (er !== 1'b1 || rd !== ERRV) begin mismatched++; $display("FAIL ill_ld_rsp: got %b/%h want 1/%h", er, rd, ERRV); end
    compared++; if (bus_wstrb[1] !== 4'b0000 || bus_addr[1] !== 32'h0) begin mismatched++; $display("FAIL ill_ld_bus: got %b/%h want 0/0", bus_wstrb[1], bus_addr[1]); end
    run_req(1'b1, 3'b100, 32'h10, 32'h12345678, lat, rd, er);
    compared++; if (lat !== 1 || er !== 1'b1 || rd !== ERRV) begin mismatched++; $display("FAIL ill_st_rsp: got %0d/%b/%h want 1/1/%h", lat, er, rd, ERRV); end
    compared++; if (bus_wstrb[1] !== 4'b0000) begin mismatched++; $display("FAIL ill_st_wstrb: got %b want 0000", bus_wstrb[1]); end
    run_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er);
    compared++; if (rd !== 32'hA5223344) begin mismatched++; $display("FAIL ill_st_nowrite: got %h want a5223344", rd); end
  endtask

  task automatic test_misalign();
    int lat; logic [31:0] rd; logic er;
    run_req(1'b1, 3'b010, 32'h20, 32'h44332211, lat, rd, er);
    run_req(1'b1, 3'b010, 32'h24, 32'h88776655, lat, rd, er);
`ifdef LSU_MISALIGN_EN
    run_req(1'b0, 3'b001, 32'h21, 32'h0, lat, rd, er);
    compared++; if (lat !== 2 || rd !== 32'h00003322 || er !== 1'b0) begin mismatched++; $display("FAIL lh_off1: got %0d/%h/%b want 2/00003322/0", lat, rd, er); end
    run_req(1'b0, 3'b010, 32'h22, 32'h0, lat, rd, er);
    compared++; if (lat !== 3) begin mismatched++; $display("FAIL lw_split_latency: got %0d want 3", lat); end
    compared++; if (bus_addr[1] !== 32'h20 || bus_addr[2] !== 32'h24) begin mismatched++; $display("FAIL lw_split_addr: got %h/%h want 20/24", bus_addr[1], bus_addr[2]); end
    compared++; if (rd !== 32'h66554433 || er !== 1'b0) begin mismatched++; $display("FAIL lw_split_data: got %h/%b want 66554433/0", rd, er); end
    run_req(1'b1, 3'b010, 32'h23, 32'hCAFEF00D, lat, rd, er);
    compared++; if (bus_wstrb[1] !== 4'b1000 || bus_wstrb[2] !== 4'b0111) begin mismatched++; $display("FAIL sw_split_wstrb: got %b/%b want 1000/0111", bus_wstrb[1], bus_wstrb[2]); end
    compared++; if (bus_wdata[1] !== 32'h0D000000 || bus_wdata[2] !== 32'h00CAFEF0) begin mismatched++; $display("FAIL sw_split_wdata: got %h/%h want 0d000000/00cafef0", bus_wdata[1], bus_wdata[2]); end
    run_req(1'b0, 3'b010, 32'h20, 32'h0, lat, rd, er);
    compared++; if (rd !== 32'h0D332211) begin mismatched++; $display("FAIL sw_split_lo: got %h want 0d332211", rd); end
    run_req(1'b0, 3'b010, 32'h24, 32'h0, lat, rd, er);
    compared++; if (rd !== 32'h88CAFEF0) begin mismatched++; $display("FAIL sw_split_hi: got %h want 88cafef0", rd); end
`else
    run_req(1'b0, 3'b010, 32'h22, 32'h0, lat, rd, er);
    compared++; if (lat !== 1 || er !== 1'b1 || rd !== ERRV) begin mismatched++; $display("FAIL lw_mis_err: got %0d/%b/%h want 1/1/%h", lat, er, rd, ERRV); end
    run_req(1'b1, 3'b010, 32'h23, 32'hCAFEF00D, lat, rd, er);
    compared++; if (er !== 1'b1 || bus_wstrb[1] !== 4'b0000) begin mismatched++; $display("FAIL sw_mis_err: got %b/%b want 1/0000", er, bus_wstrb[1]); end
    run_req(1'b0, 3'b001, 32'h21, 32'h0, lat, rd, er);
    compared++; if (er !== 1'b1 || lat !== 1) begin mismatched++; $display("FAIL lh_mis_err: got %b/%0d want 1/1", er, lat); end
    run_req(1'b0, 3'b010, 32'h20, 32'h0, lat, rd, er);
    compared++; if (rd !== 32'h44332211) begin mismatched++; $display("FAIL mis_nowrite: got %h want 44332211", rd); end
    run_req(1'b0, 3'b001, 32'h22, 32'h0, lat, rd, er);
    compared++; if (er !== 1'b0 || rd !== 32'h00004433) begin mismatched++; $display("FAIL lh_off2: got %b/%h want 0/00004433", er, rd); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [0:2];
    logic [31:0] exps  [0:2];
    addrs[0] = 32'h10; addrs[1] = 32'h20; addrs[2] = 32'h24;
    exps[0]  = 32'hA5223344;
`ifdef LSU_MISALIGN_EN
    exps[1] = 32'h0D332211; exps[2] = 32'h88CAFEF0;
`else
    exps[1] = 32'h44332211; exps[2] = 32'h88776655;
`endif
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = addrs[0];
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_acc0_%0d: got ready=%b valid=%b want 0/0", i, req_ready, rsp_valid); end
      if (i < 2) req_addr = addrs[i+1];
      else       req_valid = 1'b0;
      tick();
      compared++; if (rsp_valid !== 1'b1 || rsp_rdata !== exps[i] || req_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_rsp_%0d: got valid=%b data=%h ready=%b want 1/%h/1", i, rsp_valid, rsp_rdata, req_ready, exps[i]); end
    end
    tick();
    compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_end: got %b want 0", rsp_valid); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = 32'h5555AAAA;
    tick();
    req_valid = 1'b0;
    compared++; if (d_wstrb !== 4'b1111) begin mismatched++; $display("FAIL rst_mid_acc0: got %b want 1111", d_wstrb); end
    #1 rst_n = 1'b0;
    #1;
    compared++; if ({d_addr, d_wdata, d_wstrb} !== 68'h0 || rsp_valid !== 1'b0) begin mismatched++; $display("FAIL rst_mid_outputs: got %h/%h/%b/%b want 0", d_addr, d_wdata, d_wstrb, rsp_valid); end
    tick();
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (rsp_valid) seen++;
    end
    compared++; if (seen !== 0) begin mismatched++; $display("FAIL rst_mid_no_rsp: got %0d pulses want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_byte_half();
    test_illegal();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
